// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// No logic. Imported by the top and the iteration step.
// Build option: MDU_SIGNED_EN adds two's complement operands to the top.
package mdu_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add multiply (LSB first) or restoring divide (MSB first).
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             op,
  input  logic [WIDTH-1:0] hi,      // MUL: partial product high half; DIV: partial remainder
  input  logic [WIDTH-1:0] lo,      // MUL: remaining multiplier bits; DIV: dividend bits / quotient
  input  logic [WIDTH-1:0] m,       // MUL: multiplicand; DIV: divisor
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;

  // Select one multiply or one divide step from the current accumulator pair.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    shifted = {hi, lo[WIDTH-1]};
    hi_nxt  = '0;
    lo_nxt  = '0;
    if (op == OP_MUL) begin
      // The carry of the add drops into the top of the shifted product.
      {hi_nxt, lo_nxt} = {sum, lo[WIDTH-1:1]};
    end else if (shifted >= {1'b0, m}) begin
      hi_nxt = WIDTH'(shifted - {1'b0, m});
      lo_nxt = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt = shifted[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_mult_div.sv
// Iterative WIDTH-bit multiply (2*WIDTH product) or divide (quotient/remainder), one step per clock.
// Latency: out_valid rises WIDTH+1 edges after accept; divide-by-zero after 1 edge.
// Backpressure: result held while out_ready=0; in_ready only in IDLE. Option: MDU_SIGNED_EN.
module seq_mult_div
  import mdu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
`ifdef MDU_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic             op_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             neg_lo;   // negate product / quotient at the end
  logic             neg_hi;   // negate remainder at the end (dividend sign)

  logic             sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_abs, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

`ifdef MDU_SIGNED_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b0;
`endif

  // Operand magnitudes: the iteration always runs unsigned, signs are reapplied at the end.
  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  always_comb begin
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_r),
    .hi     (hi_r),
    .lo     (lo_r),
    .m      (m_r),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  // Sign correction of the final step's result, used on the CALC->DONE transition.
  always_comb begin
    prod_abs = {step_hi, step_lo};
    prod_fix = neg_lo ? -prod_abs : prod_abs;
    q_fix    = neg_lo ? -step_lo : step_lo;
    r_fix    = neg_hi ? -step_hi : step_hi;
  end

  // Control FSM with operand/accumulator registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      op_r        <= OP_MUL;
      m_r         <= '0;
      hi_r        <= '0;
      lo_r        <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      res_lo      <= '0;
      res_hi      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            op_r     <= op;
            count    <= '0;
            hi_r     <= '0;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= (op == OP_MUL) ? (a_neg ^ b_neg) : a_neg;
            if (op == OP_DIV && b == '0) begin
              // No iterations needed: the raw dividend is reported as remainder.
              state       <= S_DONE;
              res_lo      <= '0;
              res_hi      <= a;
              div_by_zero <= 1'b1;
            end else begin
              state       <= S_CALC;
              div_by_zero <= 1'b0;
              m_r         <= (op == OP_MUL) ? a_mag : b_mag;
              lo_r        <= (op == OP_MUL) ? b_mag : a_mag;
            end
          end
        end
        S_CALC: begin
          hi_r  <= step_hi;
          lo_r  <= step_lo;
          count <= count + CW'(1);
          if (count == LAST) begin
            state <= S_DONE;
            count <= '0;
            if (op_r == OP_MUL) begin
              {res_hi, res_lo} <= prod_fix;
            end else begin
              res_lo <= q_fix;
              res_hi <= r_fix;
            end
          end
        end
        S_DONE: begin
          // First DONE cycle publishes the result; out_ready only counts once it is visible.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_div.sv
// Self-checking bench for seq_mult_div at WIDTH=8: vector table, corner sequences, random vs model.
// Latency and handshake timing are measured in clock edges from the accepting edge.
// Optional signed cases are compiled when MDU_SIGNED_EN is defined.
module tb_seq_mult_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] res_lo;
  logic [W-1:0] res_hi;
  logic         div_by_zero;
`ifdef MDU_SIGNED_EN
  logic         is_signed = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_mult_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
`ifdef MDU_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .res_lo      (res_lo),
    .res_hi      (res_hi),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic         o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         s;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference arithmetic: {div_by_zero, hi, lo} from plain integer math.
  function automatic logic [2*W:0] model(input logic o, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic s);
    longint sx, sy, p, q, r;
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    if (o == 1'b0) begin
      p = sx * sy;
      return {1'b0, W'(p >>> W), W'(p)};
    end
    if (y == '0) return {1'b1, x, W'(0)};
    if (s && sx == -(longint'(1) <<< (W - 1)) && sy == -1) return {1'b0, W'(0), x};
    q = sx / sy;
    r = sx % sy;
    return {1'b0, W'(r), W'(q)};
  endfunction

  // Issue one operation, measure latency, optionally stall the result, then hand it off.
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input int hold,
                        output logic [W-1:0] lo, output logic [W-1:0] hi,
                        output logic dz, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
`ifdef MDU_SIGNED_EN
    is_signed = s;
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 1'($urandom);
    a = W'($urandom);
    b = W'($urandom);
`ifdef MDU_SIGNED_EN
    is_signed = 1'($urandom);
`endif
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) chk("out_valid timeout", 32'(out_valid), 32'd1);
    lo = res_lo;
    hi = res_hi;
    dz = div_by_zero;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall res_lo", 32'(res_lo), 32'(lo));
      chk("stall res_hi", 32'(res_hi), 32'(hi));
      chk("stall div_by_zero", 32'(div_by_zero), 32'(dz));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("after handshake out_valid", 32'(out_valid), 32'd0);
    chk("after handshake in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[$];
    logic [W-1:0] lo, hi;
    logic         dz;
    int           lat;
    int           seen;
    logic [2*W:0] exp;

    vecs.push_back('{1'b0, 8'd13,  8'd11,  1'b0, 8'h8F, 8'h00, 1'b0, W + 1});
    vecs.push_back('{1'b0, 8'd255, 8'd255, 1'b0, 8'h01, 8'hFE, 1'b0, W + 1});
    vecs.push_back('{1'b1, 8'd200, 8'd7,   1'b0, 8'd28, 8'd4,  1'b0, W + 1});
    vecs.push_back('{1'b1, 8'd5,   8'd0,   1'b0, 8'd0,  8'd5,  1'b1, 1});
    vecs.push_back('{1'b0, 8'd0,   8'd0,   1'b0, 8'd0,  8'd0,  1'b0, W + 1});
    vecs.push_back('{1'b0, 8'd128, 8'd2,   1'b0, 8'h00, 8'h01, 1'b0, W + 1});
    vecs.push_back('{1'b1, 8'd255, 8'd1,   1'b0, 8'd255, 8'd0, 1'b0, W + 1});
    vecs.push_back('{1'b1, 8'd7,   8'd200, 1'b0, 8'd0,  8'd7,  1'b0, W + 1});
    vecs.push_back('{1'b1, 8'd255, 8'd255, 1'b0, 8'd1,  8'd0,  1'b0, W + 1});
    vecs.push_back('{1'b1, 8'd0,   8'd5,   1'b0, 8'd0,  8'd0,  1'b0, W + 1});
`ifdef MDU_SIGNED_EN
    vecs.push_back('{1'b0, 8'hFA,  8'd7,   1'b1, 8'hD6, 8'hFF, 1'b0, W + 1});
    vecs.push_back('{1'b1, 8'hEC,  8'd3,   1'b1, 8'hFA, 8'hFE, 1'b0, W + 1});
    vecs.push_back('{1'b1, 8'h80,  8'hFF,  1'b1, 8'h80, 8'h00, 1'b0, W + 1});
    vecs.push_back('{1'b1, 8'hF9,  8'd0,   1'b1, 8'h00, 8'hF9, 1'b1, 1});
    vecs.push_back('{1'b0, 8'hFF,  8'hFF,  1'b1, 8'h01, 8'h00, 1'b0, W + 1});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset res_lo", 32'(res_lo), 32'd0);
    chk("reset res_hi", 32'(res_hi), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    // out_ready while idle must not do anything
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle out_ready out_valid", 32'(out_valid), 32'd0);
    chk("idle out_ready in_ready", 32'(in_ready), 32'd1);

    // Directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].s, 0, lo, hi, dz, lat);
      chk($sformatf("vec%0d res_lo", i), 32'(lo), 32'(vecs[i].lo));
      chk($sformatf("vec%0d res_hi", i), 32'(hi), 32'(vecs[i].hi));
      chk($sformatf("vec%0d div_by_zero", i), 32'(dz), 32'(vecs[i].dz));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: 3 stalled cycles on 13*11
    run_op(1'b0, 8'd13, 8'd11, 1'b0, 3, lo, hi, dz, lat);
    chk("stall mul res_lo", 32'(lo), 32'h8F);
    chk("stall mul res_hi", 32'(hi), 32'h00);
    chk("stall mul latency", 32'(lat), 32'(W + 1));

    // Reset in the middle of DIV 200/7 aborts it silently
    @(negedge clk);
    in_valid = 1'b1;
    op = 1'b1;
    a = 8'd200;
    b = 8'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midop reset out_valid", 32'(out_valid), 32'd0);
    chk("midop reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("aborted op produced no result", 32'(seen), 32'd0);
    run_op(1'b0, 8'd3, 8'd4, 1'b0, 0, lo, hi, dz, lat);
    chk("post reset mul res_lo", 32'(lo), 32'd12);
    chk("post reset mul res_hi", 32'(hi), 32'd0);

    // Random operations against the reference model
    for (int i = 0; i < 150; i++) begin
      logic         ro, rs;
      logic [W-1:0] rx, ry;
      ro = 1'($urandom);
      rx = W'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
`ifdef MDU_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      exp = model(ro, rx, ry, rs);
      run_op(ro, rx, ry, rs, $urandom_range(0, 2), lo, hi, dz, lat);
      chk($sformatf("rnd%0d op=%0d %0h,%0h res_lo", i, ro, rx, ry), 32'(lo), 32'(exp[W-1:0]));
      chk($sformatf("rnd%0d op=%0d %0h,%0h res_hi", i, ro, rx, ry), 32'(hi), 32'(exp[2*W-1:W]));
      chk($sformatf("rnd%0d div_by_zero", i), 32'(dz), 32'(exp[2*W]));
      chk($sformatf("rnd%0d latency", i), 32'(lat), (ro && ry == '0) ? 32'd1 : 32'(W + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
